// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared definitions for the regfile write-port arbiter: requester indices,
// default widths and the round-robin pointer helper.
package regfile_wport_arbiter_pkg;

    // Requester slots as wired in the core.
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MUL = 1;
    localparam int unsigned REQ_MEM = 2;

    localparam int unsigned NREQ_DEFAULT    = 3;
    localparam int unsigned DATA_SZ_DEFAULT = 32;
    localparam int unsigned ENTRIES_DEFAULT = 32;
    localparam int unsigned ADDR_SZ_DEFAULT = 5;

    // Slot that gets top priority after slot idx has been served.
    function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after ptr, wrapping modulo NREQ.
module vc_rr_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = NREQ_DEFAULT,
    parameter int unsigned PTR_SZ = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]   req,
    input  logic [PTR_SZ-1:0] ptr,
    output logic [NREQ-1:0]   grant,
    output logic [PTR_SZ-1:0] grant_idx
);

    // Walk the requesters starting at ptr; the first active one wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_SZ'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the single regfile write port between NREQ writeback requesters.
// One round-robin grant per cycle feeds a registered write stage; two bypass
// ports expose the write that is in flight but not yet in the regfile.
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEFAULT,
    parameter int unsigned DATA_SZ  = DATA_SZ_DEFAULT,
    parameter int unsigned ENTRIES  = ENTRIES_DEFAULT,
    parameter int unsigned ADDR_SZ  = ADDR_SZ_DEFAULT,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic [NREQ-1:0]           req_val,
    output logic [NREQ-1:0]           req_rdy,
    input  logic [NREQ*ADDR_SZ-1:0]   req_addr,
    input  logic [NREQ*DATA_SZ-1:0]   req_data,

    output logic                      wen_p,
    output logic [ADDR_SZ-1:0]        waddr_p,
    output logic [DATA_SZ-1:0]        wdata_p,

    input  logic [ADDR_SZ-1:0]        q_addr0,
    input  logic [ADDR_SZ-1:0]        q_addr1,
    output logic                      q_hit0,
    output logic                      q_hit1,
    output logic [DATA_SZ-1:0]        q_data0,
    output logic [DATA_SZ-1:0]        q_data1
);

    localparam int unsigned PTR_SZ = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("regfile_wport_arbiter: NREQ must be 2..8");
    end
    if (ENTRIES > (1 << ADDR_SZ)) begin : g_bad_entries
        $error("regfile_wport_arbiter: ENTRIES exceeds address space");
    end

    logic [PTR_SZ-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]    grant;
    logic [PTR_SZ-1:0]  grant_idx;
    logic               xfer;
    logic [ADDR_SZ-1:0] win_addr;
    logic [DATA_SZ-1:0] win_data;
    logic               wen_d;
    logic [ADDR_SZ-1:0] waddr_d;
    logic [DATA_SZ-1:0] wdata_d;

    vc_rr_arbiter #(
        .NREQ   (NREQ),
        .PTR_SZ (PTR_SZ)
    ) u_arb (
        .req       (req_val),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is suppressed during reset so no requester sees an accept that
    // the write stage cannot capture.
    always_comb begin
        req_rdy = reset_n ? grant : '0;
        xfer    = |req_rdy;
    end

    // Select the winning requester's address and data.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_addr = req_addr[i*ADDR_SZ +: ADDR_SZ];
                win_data = req_data[i*DATA_SZ +: DATA_SZ];
            end
        end
    end

    // Next state: capture the winner; zero-register writes still consume the
    // slot and advance the pointer but never raise wen_p.
    always_comb begin
        ptr_d   = ptr_q;
        waddr_d = waddr_p;
        wdata_d = wdata_p;
        wen_d   = 1'b0;
        if (xfer) begin
            ptr_d   = PTR_SZ'(rr_next(int'(grant_idx), NREQ));
            waddr_d = win_addr;
            wdata_d = win_data;
            wen_d   = !(ZERO_REG && (win_addr == '0));
        end
    end

    // Pointer and write-stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            wen_p   <= 1'b0;
            waddr_p <= '0;
            wdata_p <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wen_p   <= wen_d;
            waddr_p <= waddr_d;
            wdata_p <= wdata_d;
        end
    end

    // Bypass: forward the in-flight write to readers that ask for its address.
    always_comb begin
        q_hit0  = wen_p && (waddr_p == q_addr0);
        q_hit1  = wen_p && (waddr_p == q_addr1);
        q_data0 = wdata_p;
        q_data1 = wdata_p;
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_regfile_wport_arbiter;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned DATA_SZ = 32;
    localparam int unsigned ADDR_SZ = 5;
    localparam int unsigned ENTRIES = 32;

    logic                    clk;
    logic                    reset_n;
    logic [NREQ-1:0]         req_val;
    logic [NREQ-1:0]         req_rdy;
    logic [NREQ*ADDR_SZ-1:0] req_addr;
    logic [NREQ*DATA_SZ-1:0] req_data;
    logic                    wen_p;
    logic [ADDR_SZ-1:0]      waddr_p;
    logic [DATA_SZ-1:0]      wdata_p;
    logic [ADDR_SZ-1:0]      q_addr0, q_addr1;
    logic                    q_hit0, q_hit1;
    logic [DATA_SZ-1:0]      q_data0, q_data1;

    int checks = 0;
    int passes = 0;

    // Reference model state.
    int                 m_ptr;
    logic               m_wen;
    logic [ADDR_SZ-1:0] m_waddr;
    logic [DATA_SZ-1:0] m_wdata;

    regfile_wport_arbiter #(
        .NREQ     (NREQ),
        .DATA_SZ  (DATA_SZ),
        .ENTRIES  (ENTRIES),
        .ADDR_SZ  (ADDR_SZ),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_addr (req_addr),
        .req_data (req_data),
        .wen_p    (wen_p),
        .waddr_p  (waddr_p),
        .wdata_p  (wdata_p),
        .q_addr0  (q_addr0),
        .q_addr1  (q_addr1),
        .q_hit0   (q_hit0),
        .q_hit1   (q_hit1),
        .q_data0  (q_data0),
        .q_data1  (q_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_winner(logic [NREQ-1:0] val, int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (val[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_rdy(logic [NREQ-1:0] val, int ptr);
        int w;
        w = exp_winner(val, ptr);
        return (w < 0) ? '0 : NREQ'(1 << w);
    endfunction

    function automatic void model_reset();
        m_ptr   = 0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endfunction

    // Apply the transfer rules to the model for the upcoming rising edge.
    function automatic void model_edge();
        int w;
        w = exp_winner(req_val, m_ptr);
        if (w >= 0) begin
            m_waddr = req_addr[w*ADDR_SZ +: ADDR_SZ];
            m_wdata = req_data[w*DATA_SZ +: DATA_SZ];
            m_wen   = (m_waddr != 0);
            m_ptr   = (w + 1) % NREQ;
        end else begin
            m_wen = 1'b0;
        end
    endfunction

    // One rising edge; returns 1 time unit after it.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_val = '0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        req_val  = 3'b111;
        req_addr = {5'd3, 5'd2, 5'd1};
        req_data = {32'hC, 32'hB, 32'hA};
        q_addr0  = '0;
        q_addr1  = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_rdy !== 3'b000) $display("FAIL reset_rdy: got %b expected 000", req_rdy);
        else passes++;
        checks++;
        if (wen_p !== 1'b0) $display("FAIL reset_wen: got %b expected 0", wen_p);
        else passes++;
        checks++;
        if (waddr_p !== 5'd0) $display("FAIL reset_waddr: got %0d expected 0", waddr_p);
        else passes++;
        checks++;
        if (wdata_p !== 32'd0) $display("FAIL reset_wdata: got %0h expected 0", wdata_p);
        else passes++;
        reset_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (req_rdy !== 3'b001) $display("FAIL reset_first_grant: got %b expected 001", req_rdy);
        else passes++;
        req_val = '0;
    endtask

    task automatic test_contention();
        logic [NREQ-1:0]    g_tab [4];
        logic [ADDR_SZ-1:0] a_tab [4];
        logic [DATA_SZ-1:0] d_tab [4];
        g_tab = '{3'b001, 3'b010, 3'b100, 3'b001};
        a_tab = '{5'd1, 5'd2, 5'd3, 5'd1};
        d_tab = '{32'hA, 32'hB, 32'hC, 32'hA};
        do_reset();
        req_val  = 3'b111;
        req_addr = {5'd3, 5'd2, 5'd1};
        req_data = {32'hC, 32'hB, 32'hA};
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (req_rdy !== g_tab[c])
                $display("FAIL contention_grant%0d: got %b expected %b", c, req_rdy, g_tab[c]);
            else passes++;
            cycle();
            checks++;
            if (wen_p !== 1'b1 || waddr_p !== a_tab[c] || wdata_p !== d_tab[c])
                $display("FAIL contention_write%0d: got wen=%b addr=%0d data=%0h expected 1/%0d/%0h",
                         c, wen_p, waddr_p, wdata_p, a_tab[c], d_tab[c]);
            else passes++;
        end
        req_val = '0;
        cycle();
        checks++;
        if (wen_p !== 1'b0) $display("FAIL contention_idle: got wen=%b expected 0", wen_p);
        else passes++;
    endtask

    task automatic test_sparse();
        do_reset();
        req_val  = 3'b100;
        req_addr = {5'd7, 5'd10, 5'd11};
        req_data = {32'h55, 32'h66, 32'h77};
        #1;
        checks++;
        if (req_rdy !== 3'b100) $display("FAIL sparse_rdy: got %b expected 100", req_rdy);
        else passes++;
        cycle();
        checks++;
        if (wen_p !== 1'b1 || waddr_p !== 5'd7 || wdata_p !== 32'h55)
            $display("FAIL sparse_write: got wen=%b addr=%0d data=%0h expected 1/7/55",
                     wen_p, waddr_p, wdata_p);
        else passes++;
        req_val = 3'b011;
        #1;
        checks++;
        if (req_rdy !== 3'b001) $display("FAIL sparse_wrap: got %b expected 001", req_rdy);
        else passes++;
        cycle();
        checks++;
        if (waddr_p !== 5'd11) $display("FAIL sparse_wrap_addr: got %0d expected 11", waddr_p);
        else passes++;
        req_val = '0;
        cycle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        req_val  = 3'b010;
        req_addr = {5'd4, 5'd0, 5'd4};
        req_data = {32'h1, 32'hFF, 32'h2};
        q_addr0  = 5'd0;
        #1;
        checks++;
        if (req_rdy !== 3'b010) $display("FAIL zero_rdy: got %b expected 010", req_rdy);
        else passes++;
        cycle();
        checks++;
        if (wen_p !== 1'b0) $display("FAIL zero_wen: got %b expected 0", wen_p);
        else passes++;
        checks++;
        if (q_hit0 !== 1'b0) $display("FAIL zero_hit: got %b expected 0", q_hit0);
        else passes++;
        req_val = 3'b111;
        #1;
        checks++;
        if (req_rdy !== 3'b100) $display("FAIL zero_ptr_adv: got %b expected 100", req_rdy);
        else passes++;
        req_val = '0;
        cycle();
    endtask

    task automatic test_bypass();
        do_reset();
        req_val  = 3'b001;
        req_addr = {5'd9, 5'd8, 5'd5};
        req_data = {32'h3, 32'h4, 32'h1234};
        q_addr0  = 5'd5;
        q_addr1  = 5'd6;
        cycle();
        req_val = '0;
        #1;
        checks++;
        if (q_hit0 !== 1'b1 || q_data0 !== 32'h1234)
            $display("FAIL bypass_hit0: got hit=%b data=%0h expected 1/1234", q_hit0, q_data0);
        else passes++;
        checks++;
        if (q_hit1 !== 1'b0) $display("FAIL bypass_miss1: got %b expected 0", q_hit1);
        else passes++;
        cycle();
        checks++;
        if (q_hit0 !== 1'b0) $display("FAIL bypass_idle: got %b expected 0", q_hit0);
        else passes++;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_val  = 3'b001;
        req_addr = {5'd1, 5'd1, 5'd9};
        req_data = {32'h0, 32'h0, $urandom()};
        cycle();
        checks++;
        if (wen_p !== 1'b1) $display("FAIL areset_pre_wen: got %b expected 1", wen_p);
        else passes++;
        req_val = 3'b111;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (wen_p !== 1'b0) $display("FAIL areset_wen_drop: got %b expected 0", wen_p);
        else passes++;
        checks++;
        if (req_rdy !== 3'b000) $display("FAIL areset_rdy: got %b expected 000", req_rdy);
        else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (req_rdy !== 3'b001) $display("FAIL areset_ptr: got %b expected 001", req_rdy);
        else passes++;
        req_val = '0;
        cycle();
        checks++;
        if (wen_p !== 1'b0) $display("FAIL areset_spurious: got wen=%b expected 0", wen_p);
        else passes++;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] er;
        logic            eh0, eh1;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req_val = NREQ'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                req_addr[i*ADDR_SZ +: ADDR_SZ] =
                    ($urandom_range(0, 7) == 0) ? 5'd0 : ADDR_SZ'($urandom_range(0, 31));
                req_data[i*DATA_SZ +: DATA_SZ] = $urandom();
            end
            q_addr0 = ($urandom_range(0, 1) == 1) ? m_waddr : ADDR_SZ'($urandom_range(0, 31));
            q_addr1 = ADDR_SZ'($urandom_range(0, 31));
            #1;
            er  = exp_rdy(req_val, m_ptr);
            eh0 = m_wen && (m_waddr == q_addr0);
            eh1 = m_wen && (m_waddr == q_addr1);
            checks++;
            if (req_rdy !== er)
                $display("FAIL rand_rdy%0d: got %b expected %b", c, req_rdy, er);
            else passes++;
            checks++;
            if (q_hit0 !== eh0 || q_hit1 !== eh1 || (eh0 && q_data0 !== m_wdata))
                $display("FAIL rand_bypass%0d: got hit=%b%b data=%0h expected hit=%b%b data=%0h",
                         c, q_hit0, q_hit1, q_data0, eh0, eh1, m_wdata);
            else passes++;
            cycle();
            checks++;
            if (wen_p !== m_wen || waddr_p !== m_waddr || wdata_p !== m_wdata)
                $display("FAIL rand_write%0d: got %b/%0d/%0h expected %b/%0d/%0h",
                         c, wen_p, waddr_p, wdata_p, m_wen, m_waddr, m_wdata);
            else passes++;
        end
        req_val = '0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_sparse();
        test_zero_reg();
        test_bypass();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single write port of a flip-flop register file (1w1r/1w2r) between NREQ writeback requesters, e.g. ALU, MUL and MEM.
- Round-robin arbitration, one grant per cycle, with a registered write stage that drives the regfile's wen_p/waddr_p/wdata_p directly.
- Provides two bypass query ports so readers can forward the write that is in flight but not yet visible in the regfile.

Parameters:
- NREQ, 3: number of writeback requesters (2..8).
- DATA_SZ, 32: regfile data width.
- ENTRIES, 32: regfile entries.
- ADDR_SZ, 5: regfile address width; ENTRIES <= 2**ADDR_SZ.
- ZERO_REG, 1: if 1, writes to address 0 are accepted but discarded.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- req_val  in  NREQ  per-requester write valid.
- req_rdy  out  NREQ  per-requester grant/accept (combinational).
- req_addr  in  NREQ*ADDR_SZ  packed destination addresses; requester i at [i*ADDR_SZ +: ADDR_SZ].
- req_data  in  NREQ*DATA_SZ  packed write data; requester i at [i*DATA_SZ +: DATA_SZ].
- wen_p  out  1  registered write enable to regfile.
- waddr_p  out  ADDR_SZ  registered write address to regfile.
- wdata_p  out  DATA_SZ  registered write data to regfile.
- q_addr0, q_addr1  in  ADDR_SZ each  bypass query addresses.
- q_hit0, q_hit1  out  1 each  query matches the in-flight write.
- q_data0, q_data1  out  DATA_SZ each  in-flight write data; valid when the corresponding hit is 1.

Behaviour:
- State:
  - ptr: round-robin priority pointer, range 0..NREQ-1.
  - Write stage registers: wen_p, waddr_p, wdata_p.
- Reset (reset_n low, asynchronous):
  - ptr=0, wen_p=0, waddr_p=0, wdata_p=0.
  - req_rdy forced all-zero while reset_n is low.
  - Asserting reset mid-operation drops wen_p immediately, without waiting for a clock edge, so the in-flight write is lost.
- Arbitration (combinational):
  - The winner is the first i with req_val[i]=1, searching ptr, ptr+1, ... with wrap modulo NREQ.
  - req_rdy[winner]=1; all other rdy bits are 0.
  - At most one rdy is high; rdy is never high without its val.
- Transfer occurs on a rising edge when req_val[i] & req_rdy[i].
- The write port never stalls, so any valid request is granted within NREQ cycles. No starvation.
- On transfer, at the next edge:
  - waddr_p <= req_addr[i]; wdata_p <= req_data[i].
  - wen_p <= 1, unless ZERO_REG=1 and req_addr[i]==0, in which case wen_p <= 0.
  - ptr <= (i+1) mod NREQ; wraps from NREQ-1 to 0.
  - The ptr advance applies to discarded zero-register writes too.
- No transfer: wen_p <= 0; ptr, waddr_p and wdata_p hold.
- Latency: a request accepted in cycle t appears on wen_p/waddr_p/wdata_p in cycle t+1. The regfile contents update at the end of cycle t+1, so they are readable in cycle t+2.
- Bypass (combinational):
  - q_hitK = wen_p & (waddr_p == q_addrK).
  - q_dataK = wdata_p.
  - No match when wen_p=0, so discarded zero-register writes never hit.
- Back-to-back writes to the same address by different requesters go in grant order; the later one wins in the regfile.
- Addresses >= ENTRIES are passed through unchanged; range checking is the requester's responsibility.

Decomposition:
- Shared header holds the requester index constants (REQ_ALU=0, REQ_MUL=1, REQ_MEM=2) and ADDR_SZ/DATA_SZ defaults used by the core.
- One sub-module: vc_rr_arbiter, with inputs (req[NREQ], ptr[clog2 NREQ]) and outputs (grant one-hot, grant_idx). It is purely combinational.
- ptr state lives in regfile_wport_arbiter so that it advances only on transfer.

Test Plan:
- Reset:
  - Stimulus: hold reset_n=0 with req_val=3'b111.
  - Required: req_rdy=0, wen_p=0, waddr_p=0.
  - Then release reset: first grant is req0.
- Full contention:
  - Stimulus: req_val=3'b111 for 4 cycles, addrs 1/2/3, data 0xA/0xB/0xC.
  - Required: grants 0,1,2,0 in successive cycles.
  - wen_p=1 from the cycle after the first grant, with waddr_p sequence 1,2,3,1 and wdata_p sequence 0xA,0xB,0xC,0xA.
- Sparse request:
  - Stimulus: ptr=0, only req2 valid with addr 7, data 0x55.
  - Required: rdy=3'b100 in the same cycle.
  - Next cycle: wen_p=1, waddr_p=7, ptr=0.
  - Then req0 and req1 both valid: req0 is granted.
- Zero register:
  - Stimulus: ZERO_REG=1, req1 writes addr 0, data 0xFF.
  - Required: rdy[1]=1.
  - Next cycle: wen_p=0, q_addr0=0 gives q_hit0=0, ptr=2.
- Bypass:
  - Stimulus: req0 writes addr 5, data 0x1234.
  - Next cycle: q_addr0=5 gives q_hit0=1, q_data0=0x1234; q_addr1=6 gives q_hit1=0.
  - Following idle cycle: q_hit0=0.
- Async reset mid-write:
  - Stimulus: while wen_p=1, drop reset_n between clock edges.
  - Required: wen_p=0 before the next edge.
  - After release: ptr=0 and no spurious write.
